// File: rtl/keyword_cmd_sequencer.sv
// Purpose: turns debounced keyword codes into wake-gated commands, queued and sent over valid/ready.
// Latency: keyword seen at edge k is pushed at k+1; cmd_valid rises after k+1 if the queue was empty and idle.
// Backpressure: cmd_ready low holds the head stable; a full queue drops new commands (sticky overflow).
module keyword_cmd_sequencer #(
    parameter int              KW_W        = 4,
    parameter logic [KW_W-1:0] NONE_KW     = '0,
    parameter logic [KW_W-1:0] WAKE_KW     = KW_W'(1),
    parameter int              ARM_TIMEOUT = 100000,
    parameter int              FIFO_DEPTH  = 4,
    parameter int              COOLDOWN    = 1000,
    parameter int              LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KW_W-1:0]  keyword_in,
    output logic [KW_W-1:0]  cmd_data,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             armed,
    output logic             overflow,
    output logic [7:0]       drop_count,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int TMR_W = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
    localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(ARM_TIMEOUT - 1);
    localparam logic [CD_W-1:0]  CD_RELOAD  = CD_W'(COOLDOWN);
    localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(FIFO_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t              state;
    logic [KW_W-1:0]     kw_q;
    logic [KW_W-1:0]     kw_prev;
    logic [TMR_W-1:0]    timer;
    logic [KW_W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CD_W-1:0]     cooldown;

    logic evt;
    logic push_req;
    logic full;
    logic xfer;
    logic push;
    logic drop;

    // A held code yields one event; silence never counts as an event.
    assign evt      = (kw_q != kw_prev) && (kw_q != NONE_KW);
    assign push_req = (state == ARMED) && evt && (kw_q != WAKE_KW);
    assign full     = (fifo_level == FULL_LVL);
    assign xfer     = cmd_valid && cmd_ready;
    // A pop in the same edge frees the slot, so a push to a full queue still lands.
    assign push     = push_req && (!full || xfer);
    assign drop     = push_req && full && !xfer;

    // Outputs depend only on registered state, never on cmd_ready.
    assign cmd_valid = (fifo_level != '0) && (cooldown == '0);
    assign cmd_data  = mem[rd_ptr];

    // Two-stage keyword history for edge-style event detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kw_q    <= NONE_KW;
            kw_prev <= NONE_KW;
        end else begin
            kw_q    <= keyword_in;
            kw_prev <= kw_q;
        end
    end

    // Wake gating: any event while armed reloads the timer, so an event beats expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            armed <= 1'b0;
            timer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (evt && (kw_q == WAKE_KW)) begin
                        state <= ARMED;
                        armed <= 1'b1;
                        timer <= TMR_RELOAD;
                    end
                end
                ARMED: begin
                    if (evt) begin
                        timer <= TMR_RELOAD;
                    end else if (timer == '0) begin
                        state <= IDLE;
                        armed <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    armed <= 1'b0;
                    timer <= '0;
                end
            endcase
        end
    end

    // Command queue storage and pointers; entries are cleared so cmd_data reads 0 from reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= kw_q;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (xfer) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy count; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_level <= '0;
        end else begin
            case ({push, xfer})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Forced idle gap after each accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cooldown <= '0;
        end else if (xfer) begin
            cooldown <= CD_RELOAD;
        end else if (cooldown != '0) begin
            cooldown <= cooldown - 1'b1;
        end
    end

    // Drop accounting: sticky flag plus saturating counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/keyword_cmd_sequencer.md
Name: keyword_cmd_sequencer

Overview:
- Sits downstream of the keyword debouncer and turns its stable 4-bit keyword code into discrete command transactions for the actuator/LED/UART back-end.
- Gates commands behind a wake keyword with an inactivity timeout.
- Queues commands in a small FIFO and dispatches them over a valid/ready handshake, with a minimum spacing between transfers.

Parameters:
- KW_W, 4, keyword code width
- NONE_KW, 4'd0, "no keyword / silence" code
- WAKE_KW, 4'd1, wake keyword code
- ARM_TIMEOUT, 100000, cycles ARMED persists without a new event; must be ≥1
- FIFO_DEPTH, 4, command queue depth; power of 2, ≥2
- COOLDOWN, 1000, idle cycles forced after each accepted transfer; 0 disables
- LVL_W, $clog2(FIFO_DEPTH)+1, fifo_level width (derived)

Ports:
- clk, in, 1, system clock
- rst, in, 1, asynchronous active-high reset
- keyword_in, in, KW_W, debounced keyword from debouncer
- cmd_data, out, KW_W, command code at FIFO head
- cmd_valid, out, 1, command available
- cmd_ready, in, 1, consumer accepts command
- armed, out, 1, FSM in ARMED
- overflow, out, 1, sticky: a command was dropped on a full FIFO
- drop_count, out, 8, saturating count of FIFO-full drops
- fifo_level, out, LVL_W, queued entries

Behaviour:
- Reset is asynchronous and active-high on rst; all state clears at once:
  - kw_q and kw_prev = NONE_KW
  - state = IDLE, armed = 0, timer = 0
  - FIFO empty, fifo_level = 0, cmd_valid = 0, cmd_data = 0
  - cooldown counter = 0, overflow = 0, drop_count = 0
  - Reset mid-transfer discards queued commands. No partial handshake survives.
- Event detect: at each edge, kw_q <= keyword_in and kw_prev <= kw_q.
  - evt = (kw_q != kw_prev) && (kw_q != NONE_KW). This is combinational from the registers.
  - A held keyword gives exactly one event. Repeating the same command needs an intervening NONE_KW or a different code.
- FSM, updated at the edge following evt:
  - IDLE:
    - evt with WAKE_KW -> ARMED, timer <= ARM_TIMEOUT-1.
    - All other events are ignored. No push, no drop count.
  - ARMED, evt with WAKE_KW: stay; timer reloads; no push.
  - ARMED, evt with any other code: push code to FIFO; timer reloads.
  - ARMED, no evt and timer == 0: -> IDLE.
  - ARMED, no evt and timer != 0: timer decrements.
  - evt and timer == 0 in the same cycle: the event wins. The code is processed and the timer reloads.
  - armed = (state == ARMED), registered.
- FIFO:
  - Circular buffer with read/write pointers; fifo_level is a registered count.
  - Push when full and no pop in the same cycle:
    - code is dropped
    - overflow <= 1, sticky until rst
    - drop_count increments, saturating at 255
  - Simultaneous push and pop, including when full: both occur and the level is unchanged.
  - Pop happens only on a transfer, i.e. cmd_valid && cmd_ready at the edge.
  - The FIFO drains regardless of FSM state. Commands queued before timeout are still delivered.
- Dispatch:
  - cmd_valid = (fifo_level != 0) && (cooldown == 0).
  - cmd_data = FIFO head. Both are driven from registered state only; no combinational path from cmd_ready.
  - Once cmd_valid is high, cmd_valid and cmd_data stay stable until the transfer completes.
  - On transfer, cooldown <= COOLDOWN. It decrements to 0, and cmd_valid stays low while it is nonzero.
  - With COOLDOWN = 0, back-to-back transfers occur on consecutive cycles.
  - When cmd_data is not valid it holds the last head value (don't-care). The bench checks it only while cmd_valid = 1.
- Latency:
  - keyword_in changes before edge k; evt is high between k and k+1; push happens at k+1.
  - cmd_valid is high in the cycle after k+1, given the FIFO was empty and cooldown = 0.
- keyword_in is assumed synchronous to clk (the debouncer is on the same clock). No internal synchronizer.

Test Plan:
Parameter overrides for all scenarios: ARM_TIMEOUT=20, COOLDOWN=4, FIFO_DEPTH=4.
- Reset/gating: rst high 2 cycles, then keyword_in=3 for 10 cycles with cmd_ready=1 -> armed=0, cmd_valid never 1, fifo_level=0, drop_count=0.
- Arm and dispatch: keyword_in 1, then 0, then 3 (each held 5 cycles), cmd_ready=1 -> armed=1 two edges after the 1 appears; exactly one transfer with cmd_data=3; cmd_valid low for 4 cycles afterwards.
- Timeout: arm with 1, then keyword_in=0 -> armed drops after exactly 20 cycles. A later 5 produces no push. Re-arming with 1 followed by 5 pushes 5.
- Backpressure/overflow:
  - Setup: armed, cmd_ready=0; apply the code sequence 2,0,3,0,4,0,5,0,6,0,7.
  - Queue: fifo_level=4; cmd_data=2 held stable while cmd_valid and !cmd_ready.
  - Drops: codes 6 and 7 dropped, so drop_count=2 and overflow=1.
  - Drain: raising cmd_ready delivers 2,3,4,5 in order, spaced 5 cycles apart.
- Hold/no-repeat: armed, keyword_in=5 held 50 cycles -> exactly one push. Timeout vs event: a 6 arriving in the timer==0 cycle is pushed and armed stays 1.
- Reset mid-operation: fifo_level=3 and cmd_valid=1, assert rst asynchronously between edges -> cmd_valid, armed, fifo_level and overflow read 0 immediately, before the next edge.
